parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: synchronises and debounces five buttons, then runs one
// request/acknowledge transaction at a time. Optional statistics: PARKING_GATE_STATS_EN.
module parking_gate_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned ACK_TIMEOUT  = 8,
  parameter int unsigned DOOR_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_enter,
  input  logic [3:0] btn_exit,
  input  logic [3:0] occupancy,
  input  logic       door_open_pulse,
  output logic [3:0] req,
  output logic       busy,
  output logic       door_led,
  output logic       reject_pulse
`ifdef PARKING_GATE_STATS_EN
  ,
  output logic [7:0] cnt_enter,
  output logic [7:0] cnt_exit,
  output logic [7:0] cnt_reject
`endif
);

  localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYC - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(DOOR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, WAIT_ACK, DOOR, REJECT
  } state_t;

  // Bit 4 is the enter button, bits 3:0 the exit buttons.
  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0] deb_lvl;
  logic [4:0] deb_dly_q, deb_dly_d;
  logic [4:0] press;

  assign btn_raw = {btn_enter, btn_exit};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_dly_d = deb_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_dly_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_dly_q <= deb_dly_d;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_deb
    logic [7:0] cnt_q, cnt_d;
    logic       lvl_q, lvl_d;

    // Counts consecutive samples disagreeing with the held level; any agreeing sample restarts it.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[gi] != lvl_q) begin
        if (cnt_q == DEB_LAST) begin
          lvl_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign deb_lvl[gi] = lvl_q;
  end

  assign press = deb_lvl & ~deb_dly_q;

  state_t      state_q, state_d;
  logic        is_exit_q, is_exit_d;
  logic [1:0]  spot_q, spot_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  req_q, req_d;

  always_comb begin
    state_d   = state_q;
    is_exit_d = is_exit_q;
    spot_d    = spot_q;
    timer_d   = timer_q;
    req_d     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (press[3:0] != 4'b0000) begin
          is_exit_d = 1'b1;
          state_d   = CHECK;
          if (press[0])      spot_d = 2'd0;
          else if (press[1]) spot_d = 2'd1;
          else if (press[2]) spot_d = 2'd2;
          else               spot_d = 2'd3;
        end else if (press[4]) begin
          is_exit_d = 1'b0;
          spot_d    = 2'd0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (is_exit_q ? !occupancy[spot_q] : (occupancy == 4'b1111)) begin
          state_d = REJECT;
        end else begin
          state_d = ISSUE;
          // req is registered, so it is loaded here to be valid during ISSUE.
          req_d   = is_exit_q ? {2'b01, spot_q} : 4'b1000;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (door_open_pulse) begin
          state_d = DOOR;
          timer_d = '0;
        end else if (timer_q == ACK_LAST) begin
          state_d = REJECT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DOOR: begin
        if (timer_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_exit_q <= 1'b0;
      spot_q    <= 2'd0;
      timer_q   <= '0;
      req_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      is_exit_q <= is_exit_d;
      spot_q    <= spot_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
    end
  end

  assign req          = req_q;
  assign busy         = (state_q != IDLE);
  assign door_led     = (state_q == DOOR);
  assign reject_pulse = (state_q == REJECT);

`ifdef PARKING_GATE_STATS_EN
  logic [7:0] cnt_enter_q, cnt_enter_d;
  logic [7:0] cnt_exit_q, cnt_exit_d;
  logic [7:0] cnt_reject_q, cnt_reject_d;
  logic       door_entry;

  assign door_entry = (state_q == WAIT_ACK) && (state_d == DOOR);

  always_comb begin
    cnt_enter_d  = cnt_enter_q;
    cnt_exit_d   = cnt_exit_q;
    cnt_reject_d = cnt_reject_q;
    if (door_entry && !is_exit_q && (cnt_enter_q != 8'hFF)) cnt_enter_d = cnt_enter_q + 8'd1;
    if (door_entry && is_exit_q && (cnt_exit_q != 8'hFF))   cnt_exit_d  = cnt_exit_q + 8'd1;
    if ((state_d == REJECT) && (state_q != REJECT) && (cnt_reject_q != 8'hFF)) begin
      cnt_reject_d = cnt_reject_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_enter_q  <= '0;
      cnt_exit_q   <= '0;
      cnt_reject_q <= '0;
    end else begin
      cnt_enter_q  <= cnt_enter_d;
      cnt_exit_q   <= cnt_exit_d;
      cnt_reject_q <= cnt_reject_d;
    end
  end

  assign cnt_enter  = cnt_enter_q;
  assign cnt_exit   = cnt_exit_q;
  assign cnt_reject = cnt_reject_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a table of whole transactions plus
// hand-written sequences for glitch, stray acknowledge and reset corner cases.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_enter = 1'b0;
  logic [3:0] btn_exit = 4'b0000;
  logic [3:0] occupancy = 4'b0000;
  logic       door_open_pulse = 1'b0;
  logic [3:0] req;
  logic       busy;
  logic       door_led;
  logic       reject_pulse;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl #(
    .DEBOUNCE_CYC(4),
    .ACK_TIMEOUT (8),
    .DOOR_HOLD   (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_enter      (btn_enter),
    .btn_exit       (btn_exit),
    .occupancy      (occupancy),
    .door_open_pulse(door_open_pulse),
    .req            (req),
    .busy           (busy),
    .door_led       (door_led),
    .reject_pulse   (reject_pulse)
  );

  typedef struct {
    logic       enter;
    logic [3:0] ex;
    logic [3:0] occ;
    int         ack_dly;   // negedges after the req cycle to pulse ack; 0 = never
    logic [3:0] exp_req;
    int         exp_nreq;
    int         exp_rej;
    int         exp_led;
    int         exp_gap;   // cycles from req to reject_pulse; 0 = not checked
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int n_req = 0;
    int n_rej = 0;
    int n_led = 0;
    int req_c = -1;
    int rej_c = -1;
    int ack_at = -1;
    logic [3:0] req_w = 4'b0000;
    @(negedge clk);
    btn_enter = v.enter;
    btn_exit  = v.ex;
    occupancy = v.occ;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 9) begin
        btn_enter = 1'b0;
        btn_exit  = 4'b0000;
      end
      if (req != 4'b0000) begin
        n_req++;
        req_w = req;
        req_c = c;
        if (v.ack_dly > 0) ack_at = c + v.ack_dly;
      end
      if (reject_pulse) begin
        n_rej++;
        rej_c = c;
      end
      if (door_led) n_led++;
      door_open_pulse = (c == ack_at);
    end
    door_open_pulse = 1'b0;
    $display("txn %0d: req=%b req_cycles=%0d rejects=%0d led_cycles=%0d busy=%0b",
             idx, req_w, n_req, n_rej, n_led, busy);
    check($sformatf("txn%0d_req_word", idx), 32'(req_w), 32'(v.exp_req));
    check($sformatf("txn%0d_req_cycles", idx), n_req, v.exp_nreq);
    check($sformatf("txn%0d_reject_count", idx), n_rej, v.exp_rej);
    check($sformatf("txn%0d_led_cycles", idx), n_led, v.exp_led);
    check($sformatf("txn%0d_busy_end", idx), 32'(busy), 32'd0);
    if (v.exp_gap > 0) check($sformatf("txn%0d_timeout_gap", idx), rej_c - req_c, v.exp_gap);
  endtask

  initial begin
    int   busy_cnt;
    int   req_cnt;
    logic got;

    //           enter  exit     occ      ack req      nreq rej led gap
    vecs[0] = '{1'b1, 4'b0000, 4'b0000, 1, 4'b1000, 1,   0,  16, 0};
    vecs[1] = '{1'b0, 4'b0100, 4'b0100, 1, 4'b0110, 1,   0,  16, 0};
    vecs[2] = '{1'b0, 4'b0100, 4'b0000, 1, 4'b0000, 0,   1,  0,  0};
    vecs[3] = '{1'b1, 4'b0000, 4'b1111, 1, 4'b0000, 0,   1,  0,  0};
    vecs[4] = '{1'b1, 4'b1010, 4'b1111, 1, 4'b0101, 1,   0,  16, 0};
    vecs[5] = '{1'b1, 4'b0000, 4'b0000, 0, 4'b1000, 1,   1,  0,  9};
    vecs[6] = '{1'b1, 4'b0000, 4'b0000, 8, 4'b1000, 1,   0,  16, 0};
    vecs[7] = '{1'b0, 4'b1000, 4'b1000, 3, 4'b0111, 1,   0,  16, 0};
    vecs[8] = '{1'b0, 4'b0001, 4'b1110, 1, 4'b0000, 0,   1,  0,  0};
    vecs[9] = '{1'b1, 4'b0000, 4'b0111, 1, 4'b1000, 1,   0,  16, 0};

    // Outputs held at zero during reset.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req, busy, door_led, reject_pulse}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Three-cycle glitch must not qualify.
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    $display("txn glitch: busy_cycles=%0d", busy_cnt);
    check("glitch_busy_cycles", busy_cnt, 0);

    // Acknowledge while idle is ignored.
    door_open_pulse = 1'b1;
    @(negedge clk);
    door_open_pulse = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || door_led) busy_cnt++;
    end
    $display("txn stray_ack: active_cycles=%0d", busy_cnt);
    check("stray_ack_active", busy_cnt, 0);

    // Reset during DOOR clears the indicator immediately.
    btn_enter = 1'b1;
    occupancy = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (c == 9) btn_enter = 1'b0;
      if (req == 4'b1000) got = 1'b1;
    end
    btn_enter = 1'b0;
    check("rst_door_req_seen", 32'(got), 32'd1);
    @(negedge clk);
    door_open_pulse = 1'b1;
    @(negedge clk);
    door_open_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_door_led_before", 32'(door_led), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn reset_in_door: door_led=%0b busy=%0b", door_led, busy);
    check("rst_door_led_after", 32'(door_led), 32'd0);
    check("rst_door_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    req_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (req != 4'b0000 || reject_pulse) req_cnt++;
    end
    check("rst_door_idle_busy", busy_cnt, 0);
    check("rst_door_no_req", req_cnt, 0);

    // Button already held when reset releases produces a press.
    @(negedge clk);
    rst_n = 1'b0;
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (req == 4'b1000) got = 1'b1;
    end
    btn_enter = 1'b0;
    $display("txn held_at_reset: req_seen=%0b", got);
    check("held_reset_req_seen", 32'(got), 32'd1);
    @(negedge clk);
    door_open_pulse = 1'b1;
    @(negedge clk);
    door_open_pulse = 1'b0;
    check("held_reset_door_led", 32'(door_led), 32'd1);
    repeat (30) @(negedge clk);
    check("held_reset_busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
